gpio_pad_ctrl: RTL
==================

Name: gpio_pad_ctrl

Overview:
- Register-controlled GPIO stage directly upstream and downstream of the per-pin bidirectional pad buffer bank.
- Drives each pin's output value and output enable into the buffer bank.
- Takes the raw pad readback from the bank, synchronizes it and detects edges.
- Raises a level interrupt on enabled rising/falling edges; software reaches it through a simple single-cycle register port.

Parameters:
Width, 32, number of pins; must equal the size of the attached pad buffer bank.
DebounceCycles, 4, stability window in cycles, used only when GPIO_PAD_DEBOUNCE_EN is defined; minimum 1.

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
req_i  input  1  register access request, one access per cycle
we_i  input  1  1 = write, 0 = read
addr_i  input  3  word register index
wdata_i  input  Width  write data
rvalid_o  output  1  read/write response, one cycle after req_i
rdata_o  output  Width  read data, valid with rvalid_o
pad_out_o  output  Width  output value to the buffer bank data input
pad_oe_o  output  Width  output enable to the buffer bank (1 = drive pad)
pad_in_i  input  Width  raw asynchronous pad readback from the buffer bank
irq_o  output  1  OR of IRQ_STATUS

Behaviour:
- Reset (asynchronous, rst_ni low): all registers, sync flops, debounce state, rvalid_o, rdata_o and irq_o are 0.
  - pad_oe_o = 0, so all pads are tristated.
- Register map (addr_i):
  - 0 DIR rw: drives pad_oe_o.
  - 1 OUT rw: drives pad_out_o.
  - 2 IN ro: filtered input; writes ignored.
  - 3 RISE_EN rw.
  - 4 FALL_EN rw.
  - 5 IRQ_STATUS rw1c.
  - 6 OUT_SET wo: OUT |= wdata; reads 0.
  - 7 OUT_CLR wo: OUT &= ~wdata; reads 0.
- Access timing:
  - A write updates the target register at the sampling edge.
  - pad_out_o and pad_oe_o are driven straight from the DIR/OUT flops, so they change one cycle after req_i.
  - rvalid_o is a registered copy of req_i.
  - For reads, rdata_o is registered from the value at the request edge; for writes, rdata_o = 0.
  - No backpressure.
- Input path:
  - 2-flop synchronizer per pin: sync1 <= pad_in_i, sync2 <= sync1.
  - Without debounce, cur = sync2. prev <= cur every cycle.
  - rise = cur & ~prev; fall = ~cur & prev.
  - Latency: pad change sampled at edge N shows in IN at edge N+1; the status bit sets at edge N+2.
- IRQ_STATUS[i] next value:
  - set if (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]);
  - otherwise cleared if a write to addr 5 has wdata[i] = 1;
  - otherwise held.
  - If an event and a W1C hit the same bit in the same cycle, the event wins and the bit stays 1.
- Enables gate the setting of status bits only. Clearing an enable does not clear a pending bit.
- irq_o = |IRQ_STATUS; combinational from flops, no extra latency.
- Loopback: pins with DIR = 1 still sample their own driven value. Toggling OUT can therefore raise edge interrupts; this is intended.
- Reset mid-operation clears everything immediately. After release, prev = 0, so a pin held high produces one rise event three cycles later if RISE_EN is set.

Optional Feature:
- Macro GPIO_PAD_DEBOUNCE_EN.
- Defined:
  - Each pin has a counter of width $clog2(DebounceCycles+1) and a filtered register filt (reset 0).
  - When sync2 != filt, the counter increments. When it reaches DebounceCycles, filt <= sync2 and the counter resets to 0.
  - When sync2 == filt, the counter resets to 0.
  - cur = filt.
  - Pulses shorter than DebounceCycles cycles never reach IN or IRQ_STATUS.
  - Added latency is exactly DebounceCycles cycles.
- Undefined: cur = sync2, no counters, and the DebounceCycles parameter is unused.

Test Plan:
- Reset values: assert rst_ni low mid-run -> pad_oe_o = 0, pad_out_o = 0, irq_o = 0. Read each of addr 0..7 -> rdata_o = 0, rvalid_o one cycle after each req_i.
- Output path: write DIR = 0x0000_00FF, OUT = 0x0000_00A5, OUT_SET = 0x0000_0100, OUT_CLR = 0x0000_0001.
  - pad_oe_o = 0xFF.
  - pad_out_o reads back 0x0000_01A4; each change is visible one cycle after its req_i.
- Edge irq: RISE_EN = 0x1, pad_in_i[0] 0->1 at edge N.
  - IN[0] = 1 at N+1; IRQ_STATUS = 0x1 and irq_o = 1 at N+2.
  - Falling edge with FALL_EN = 0 -> no change.
- W1C vs event: write IRQ_STATUS = 0x1 in the same cycle a new enabled rise on pin 0 is detected -> bit stays 1.
  - Repeat the write with no event -> bit 0 cleared, irq_o = 0.
- Disabled edges: toggle pad_in_i[5] with RISE_EN = FALL_EN = 0 -> IRQ_STATUS stays 0; IN tracks the pin with 2-cycle latency.
- Debounce (macro defined, DebounceCycles = 4):
  - 3-cycle high glitch on pin 2 -> IN[2] stays 0 and no irq.
  - 6-cycle high pulse -> IN[2] = 1 exactly 4 cycles later than the undefined build.

Source files
------------

// File: rtl/gpio_pad_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gpio_pad_ctrl
// Description : Register-controlled GPIO stage sitting between the register
//               port and the bidirectional pad buffer bank. It drives the
//               pad data/enable, synchronises readback and raises edge IRQs.
//               Optional input debounce filter: GPIO_PAD_DEBOUNCE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_pad_ctrl #(
    parameter int WIDTH           = 32,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_i,
    input  logic             we_i,
    input  logic [2:0]       addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             rvalid_o,
    output logic [WIDTH-1:0] rdata_o,
    output logic [WIDTH-1:0] pad_out_o,
    output logic [WIDTH-1:0] pad_oe_o,
    input  logic [WIDTH-1:0] pad_in_i,
    output logic             irq_o
);

    localparam logic [2:0] c_addr_dir  = 3'd0;
    localparam logic [2:0] c_addr_out  = 3'd1;
    localparam logic [2:0] c_addr_in   = 3'd2;
    localparam logic [2:0] c_addr_rise = 3'd3;
    localparam logic [2:0] c_addr_fall = 3'd4;
    localparam logic [2:0] c_addr_sts  = 3'd5;
    localparam logic [2:0] c_addr_set  = 3'd6;
    localparam logic [2:0] c_addr_clr  = 3'd7;

    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_rise_en;
    logic [WIDTH-1:0] r_fall_en;
    logic [WIDTH-1:0] r_irq_status;
    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_prev;
    logic             r_rvalid;
    logic [WIDTH-1:0] r_rdata;

    logic             w_wr;
    logic             w_rd;
    logic [WIDTH-1:0] w_cur;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_rd_mux;

    assign w_wr = req_i & we_i;
    assign w_rd = req_i & ~we_i;

    // Input synchroniser and previous-value register for edge detection
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= pad_in_i;
            r_sync2 <= r_sync1;
            r_prev  <= w_cur;
        end
    end

    // A zero-length stability window degenerates to a plain wire.
    generate
        if (DEBOUNCE_CYCLES > 0) begin : g_filter
`ifdef GPIO_PAD_DEBOUNCE_EN
            localparam int              c_cw       = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [c_cw-1:0] c_cnt_last = c_cw'(DEBOUNCE_CYCLES - 1);
            localparam logic [c_cw-1:0] c_cnt_one  = c_cw'(1);

            for (genvar i = 0; i < WIDTH; i++) begin : g_pin
                logic [c_cw-1:0] r_cnt;
                logic            r_filt;

                // Commit the new level on the cycle the count would reach the window.
                always_ff @(posedge clk_i or negedge rst_ni) begin
                    if (!rst_ni) begin
                        r_cnt  <= '0;
                        r_filt <= 1'b0;
                    end else if (r_sync2[i] != r_filt) begin
                        if (r_cnt == c_cnt_last) begin
                            r_filt <= r_sync2[i];
                            r_cnt  <= '0;
                        end else begin
                            r_cnt <= r_cnt + c_cnt_one;
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                end

                assign w_cur[i] = r_filt;
            end
`else
            assign w_cur = r_sync2;
`endif
        end else begin : g_bypass
            assign w_cur = r_sync2;
        end
    endgenerate

    assign w_rise = w_cur & ~r_prev;
    assign w_fall = ~w_cur & r_prev;
    assign w_set  = (w_rise & r_rise_en) | (w_fall & r_fall_en);
    assign w_clr  = (w_wr && (addr_i == c_addr_sts)) ? wdata_i : '0;

    always_comb begin
        w_rd_mux = '0;
        case (addr_i)
            c_addr_dir:  w_rd_mux = r_dir;
            c_addr_out:  w_rd_mux = r_out;
            c_addr_in:   w_rd_mux = w_cur;
            c_addr_rise: w_rd_mux = r_rise_en;
            c_addr_fall: w_rd_mux = r_fall_en;
            c_addr_sts:  w_rd_mux = r_irq_status;
            default:     w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_dir        <= '0;
            r_out        <= '0;
            r_rise_en    <= '0;
            r_fall_en    <= '0;
            r_irq_status <= '0;
            r_rvalid     <= 1'b0;
            r_rdata      <= '0;
        end else begin
            if (w_wr) begin
                case (addr_i)
                    c_addr_dir:  r_dir     <= wdata_i;
                    c_addr_out:  r_out     <= wdata_i;
                    c_addr_rise: r_rise_en <= wdata_i;
                    c_addr_fall: r_fall_en <= wdata_i;
                    c_addr_set:  r_out     <= r_out | wdata_i;
                    c_addr_clr:  r_out     <= r_out & ~wdata_i;
                    default:     ;
                endcase
            end
            // A fresh event outranks a simultaneous write-one-to-clear.
            r_irq_status <= w_set | (r_irq_status & ~w_clr);
            r_rvalid     <= req_i;
            r_rdata      <= w_rd ? w_rd_mux : '0;
        end
    end

    assign pad_oe_o  = r_dir;
    assign pad_out_o = r_out;
    assign rvalid_o  = r_rvalid;
    assign rdata_o   = r_rdata;
    assign irq_o     = |r_irq_status;

endmodule
`default_nettype wire
